// File: rtl/servo_motion_sequencer.sv
// Servo motion sequencer: holds one clamped, deadbanded target per servo and
// ramps each command toward it by at most STEP_US per frame, in a 4-cycle burst.
module servo_motion_sequencer #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned FRAME_US    = 20000,
    parameter int unsigned MIN_US      = 650,
    parameter int unsigned MAX_US      = 2600,
    parameter int unsigned CENTER_US   = 1500,
    parameter int unsigned STEP_US     = 10,
    parameter int unsigned DEADBAND_US = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  sel,
    input  logic [11:0] target_us,
    input  logic        target_valid,
    input  logic        hold,
    output logic [11:0] servo0_cmd,
    output logic [11:0] servo1_cmd,
    output logic [11:0] servo2_cmd,
    output logic [11:0] servo3_cmd,
    output logic        frame_tick,
    output logic        busy,
    output logic [3:0]  at_target
);

    localparam int unsigned US_W      = 12;
    localparam int unsigned FRAME_CYC = CLK_HZ / 1000000 * FRAME_US;
    localparam int unsigned CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;

    localparam logic [US_W-1:0]  MIN_V    = US_W'(MIN_US);
    localparam logic [US_W-1:0]  MAX_V    = US_W'(MAX_US);
    localparam logic [US_W-1:0]  CENTER_V = US_W'(CENTER_US);
    localparam logic [US_W-1:0]  STEP_V   = US_W'(STEP_US);
    localparam logic [US_W-1:0]  DB_V     = US_W'(DEADBAND_US);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic signed [US_W:0] STEP_S  = (US_W+1)'(STEP_US);
    localparam logic signed [US_W:0] NSTEP_S = (US_W+1)'(0 - STEP_US);

    typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, UPD3} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [US_W-1:0]      tgt [4];
    logic [US_W-1:0]      cmd [4];

    logic [US_W-1:0]      clamped;
    logic [US_W-1:0]      sel_tgt;
    logic [US_W-1:0]      gap;
    logic                 wr_en;
    logic [1:0]           idx;
    logic [US_W-1:0]      cur_t;
    logic [US_W-1:0]      cur_c;
    logic signed [US_W:0] d;
    logic [US_W-1:0]      next_c;

    // Incoming target: clamp to the legal range, then reject jitter inside the deadband
    always_comb begin
        clamped = target_us;
        if (target_us < MIN_V) begin
            clamped = MIN_V;
        end else if (target_us > MAX_V) begin
            clamped = MAX_V;
        end
        sel_tgt = tgt[sel];
        gap     = (clamped > sel_tgt) ? clamped - sel_tgt : sel_tgt - clamped;
        wr_en   = target_valid && (gap > DB_V);
    end

    // Step for the servo owned by the current burst slot; uses pre-write target
    always_comb begin
        case (state)
            UPD1:    idx = 2'd1;
            UPD2:    idx = 2'd2;
            UPD3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        cur_t = tgt[idx];
        cur_c = cmd[idx];
        d     = $signed({1'b0, cur_t}) - $signed({1'b0, cur_c});
        if (d > STEP_S) begin
            next_c = cur_c + STEP_V;
        end else if (d < NSTEP_S) begin
            next_c = cur_c - STEP_V;
        end else begin
            next_c = cur_t;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
            at_target  <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                tgt[i] <= CENTER_V;
                cmd[i] <= CENTER_V;
            end
        end else begin
            if (cnt == CNT_LAST) begin
                cnt        <= '0;
                frame_tick <= 1'b1;
            end else begin
                cnt        <= cnt + CNT_W'(1);
                frame_tick <= 1'b0;
            end

            if (wr_en) begin
                tgt[sel] <= clamped;
            end

            for (int i = 0; i < 4; i++) begin
                at_target[i] <= (cmd[i] == tgt[i]);
            end

            case (state)
                IDLE: begin
                    if (frame_tick && !hold) begin
                        state <= UPD0;
                        busy  <= 1'b1;
                    end
                end
                UPD0: begin
                    cmd[idx] <= next_c;
                    state    <= UPD1;
                end
                UPD1: begin
                    cmd[idx] <= next_c;
                    state    <= UPD2;
                end
                UPD2: begin
                    cmd[idx] <= next_c;
                    state    <= UPD3;
                end
                UPD3: begin
                    cmd[idx] <= next_c;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign servo0_cmd = cmd[0];
    assign servo1_cmd = cmd[1];
    assign servo2_cmd = cmd[2];
    assign servo3_cmd = cmd[3];

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Directed bench for servo_motion_sequencer with a 20-cycle frame.
module tb_servo_motion_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic [11:0] target_us = 12'd0;
    logic        target_valid = 1'b0;
    logic        hold = 1'b0;
    logic [11:0] servo0_cmd, servo1_cmd, servo2_cmd, servo3_cmd;
    logic        frame_tick, busy;
    logic [3:0]  at_target;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [11:0] tus;
        int          frames;
        int          c0, c1, c2, c3;
        logic [3:0]  at;
    } vec_t;

    vec_t vecs [9];

    servo_motion_sequencer #(
        .CLK_HZ   (1000000),
        .FRAME_US (20)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .sel          (sel),
        .target_us    (target_us),
        .target_valid (target_valid),
        .hold         (hold),
        .servo0_cmd   (servo0_cmd),
        .servo1_cmd   (servo1_cmd),
        .servo2_cmd   (servo2_cmd),
        .servo3_cmd   (servo3_cmd),
        .frame_tick   (frame_tick),
        .busy         (busy),
        .at_target    (at_target)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_cmds(input string name, input int c0, input int c1,
                            input int c2, input int c3, input int at);
        chk({name, ".cmd0"}, int'(servo0_cmd), c0);
        chk({name, ".cmd1"}, int'(servo1_cmd), c1);
        chk({name, ".cmd2"}, int'(servo2_cmd), c2);
        chk({name, ".cmd3"}, int'(servo3_cmd), c3);
        chk({name, ".at"},   int'(at_target),  at);
    endtask

    task automatic write_tgt(input logic [1:0] s, input logic [11:0] v);
        sel          = s;
        target_us    = v;
        target_valid = 1'b1;
        @(negedge CLK);
        target_valid = 1'b0;
    endtask

    // Bounded search for the next frame_tick, sampled on the falling edge
    task automatic wait_tick();
        int found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge CLK);
            if (frame_tick) found = 1;
        end
        chk("tick_timeout", found, 1);
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            wait_tick();
            repeat (7) @(negedge CLK);
        end
    endtask

    // Checks tick/busy every cycle for n cycles after reset release
    task automatic check_timing(input string name, input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge CLK);
            chk({name, ".tick"}, int'(frame_tick), (c % 20 == 0) ? 1 : 0);
            chk({name, ".busy"}, int'(busy),
                (c > 20 && (c % 20) >= 1 && (c % 20) <= 4) ? 1 : 0);
        end
    endtask

    initial begin
        int busy_cnt;
        int tick_cnt;

        vecs[0] = '{2'd2, 12'd3000, 1,  1600, 1500, 1510, 1500, 4'b1011};
        vecs[1] = '{2'd3, 12'd100,  85, 1600, 1500, 2360, 650,  4'b1011};
        vecs[2] = '{2'd3, 12'd100,  5,  1600, 1500, 2410, 650,  4'b1011};
        vecs[3] = '{2'd1, 12'd1505, 1,  1600, 1500, 2420, 650,  4'b1011};
        vecs[4] = '{2'd1, 12'd1509, 1,  1600, 1509, 2430, 650,  4'b1011};
        vecs[5] = '{2'd1, 12'd1517, 1,  1600, 1509, 2440, 650,  4'b1011};
        vecs[6] = '{2'd1, 12'd1518, 1,  1600, 1518, 2450, 650,  4'b1011};
        vecs[7] = '{2'd0, 12'd1580, 1,  1590, 1518, 2460, 650,  4'b1010};
        vecs[8] = '{2'd0, 12'd1580, 1,  1580, 1518, 2470, 650,  4'b1011};

        // Reset state
        repeat (3) @(negedge CLK);
        chk_cmds("reset", 1500, 1500, 1500, 1500, 4'b1111);
        chk("reset.tick", int'(frame_tick), 0);
        chk("reset.busy", int'(busy), 0);
        RST = 1'b0;

        // Idle frames: tick every 20 cycles, 4-cycle bursts, nothing moves
        check_timing("idle", 100);
        chk_cmds("idle", 1500, 1500, 1500, 1500, 4'b1111);
        repeat (10) @(negedge CLK);

        // Ramp servo 0 up by one step per frame
        write_tgt(2'd0, 12'd1600);
        for (int k = 1; k <= 10; k++) begin
            run_frames(1);
            chk("ramp.cmd0", int'(servo0_cmd), 1500 + 10 * k);
            chk("ramp.at0", int'(at_target[0]), (k == 10) ? 1 : 0);
        end
        chk_cmds("ramp_end", 1600, 1500, 1500, 1500, 4'b1111);

        // Clamp, deadband, snap and downward-step vectors
        for (int i = 0; i < 9; i++) begin
            write_tgt(vecs[i].sel, vecs[i].tus);
            run_frames(vecs[i].frames);
            chk_cmds($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1,
                     vecs[i].c2, vecs[i].c3, int'(vecs[i].at));
        end

        // Hold: frames skipped, writes still accepted
        hold = 1'b1;
        write_tgt(2'd0, 12'd1700);
        busy_cnt = 0;
        tick_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (busy) busy_cnt++;
            if (frame_tick) tick_cnt++;
        end
        chk("hold.busy_cycles", busy_cnt, 0);
        chk("hold.ticks", tick_cnt, 5);
        chk("hold.cmd0", int'(servo0_cmd), 1580);
        hold = 1'b0;
        run_frames(1);
        chk("unhold.cmd0", int'(servo0_cmd), 1590);
        run_frames(1);
        chk("unhold2.cmd0", int'(servo0_cmd), 1600);
        chk("unhold2.cmd2", int'(servo2_cmd), 2490);

        // Write to servo 0 during its own update slot: old target used this frame
        wait_tick();
        @(negedge CLK);
        chk("coll.busy", int'(busy), 1);
        write_tgt(2'd0, 12'd1000);
        chk("coll.cmd0", int'(servo0_cmd), 1610);
        repeat (6) @(negedge CLK);
        run_frames(1);
        chk("coll_next.cmd0", int'(servo0_cmd), 1600);

        // Reset in the middle of a burst
        write_tgt(2'd0, 12'd2000);
        run_frames(10);
        chk("pre_rst.cmd0", int'(servo0_cmd), 1700);
        wait_tick();
        @(negedge CLK);
        chk("pre_rst.busy", int'(busy), 1);
        RST = 1'b1;
        #1;
        chk_cmds("mid_rst", 1500, 1500, 1500, 1500, 4'b1111);
        chk("mid_rst.busy", int'(busy), 0);
        chk("mid_rst.tick", int'(frame_tick), 0);
        @(negedge CLK);
        RST = 1'b0;
        check_timing("post_rst", 30);
        chk_cmds("post_rst", 1500, 1500, 1500, 1500, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
